// File: rtl/mc_processor.sv
// Multicycle 16-bit datapath: 8x16 register file, 32x25 data memory, shared bus,
// one-hot control FSM. Runs one 25-bit instruction per new_func request level.
module mc_processor #(
    parameter int MEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [24:0] func,
    input  logic        new_func,
    output logic [4:0]  cur_state,
    output logic [15:0] bus,
    output logic [15:0] data,
    output logic [19:0] ous,
    output logic [24:0] mem_out,
    input  logic [2:0]  reg_dis,
    output logic [15:0] reg_val
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        DECODE = 5'b00010,
        EXEC1  = 5'b00100,
        EXEC2  = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_LDI   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_MOV   = 3'b101;
    localparam logic [2:0] OP_DISP  = 3'b110;

    state_t        state;
    logic [24:0]   ir;
    logic [AW-1:0] mar;
    logic [15:0]   mdr;
    logic [15:0]   out_reg;
    logic [15:0]   regs [8];
    logic [24:0]   mem  [MEM_DEPTH];

    logic [2:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] imm;
    logic [15:0] sum;
    logic [15:0] diff;

    assign op   = ir[24:22];
    assign rx   = ir[21:19];
    assign ry   = ir[18:16];
    assign imm  = ir[15:0];
    assign sum  = regs[rx] + regs[ry];
    assign diff = regs[rx] - regs[ry];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            out_reg <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_func) begin
                        ir    <= func;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    mar   <= ir[AW-1:0];
                    state <= EXEC1;
                end
                EXEC1: begin
                    if (op == OP_LOAD) mdr <= mem_out[15:0];
                    state <= EXEC2;
                end
                EXEC2: begin
                    case (op)
                        OP_LOAD: regs[rx] <= mdr;
                        OP_LDI:  regs[rx] <= imm;
                        OP_ADD:  regs[rx] <= sum;
                        OP_SUB:  regs[rx] <= diff;
                        OP_MOV:  regs[rx] <= regs[ry];
                        OP_DISP: out_reg  <= regs[rx];
                        default: ;
                    endcase
                    state <= DONE;
                end
                DONE: begin
                    // Hold until the request level drops so one request runs one instruction.
                    if (!new_func) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately left out of reset so stored words survive an abort.
    always_ff @(posedge clk) begin
        if (state == EXEC1 && op == OP_STORE) mem[mar] <= {9'b0, regs[rx]};
    end

    always_comb begin
        bus = '0;
        case (state)
            DECODE: bus = imm;
            EXEC1: begin
                case (op)
                    OP_LOAD:                bus = mem_out[15:0];
                    OP_STORE, OP_DISP:      bus = regs[rx];
                    OP_LDI:                 bus = imm;
                    OP_ADD, OP_SUB, OP_MOV: bus = regs[ry];
                    default:                bus = '0;
                endcase
            end
            EXEC2: begin
                case (op)
                    OP_LOAD:           bus = mdr;
                    OP_STORE, OP_DISP: bus = regs[rx];
                    OP_LDI:            bus = imm;
                    OP_ADD:            bus = sum;
                    OP_SUB:            bus = diff;
                    OP_MOV:            bus = regs[ry];
                    default:           bus = '0;
                endcase
            end
            default: bus = '0;
        endcase
    end

    assign cur_state = state;
    assign data      = mdr;
    assign ous       = {1'b0, op, out_reg};
    assign mem_out   = mem[mar];
    assign reg_val   = regs[reg_dis];

endmodule

// File: tb/tb_mc_processor.sv
// Directed self-checking bench for mc_processor: reset, each opcode class,
// wrap-around arithmetic, request hold in DONE and mid-instruction abort.
module tb_mc_processor;

    logic        clk;
    logic        rst_n;
    logic [24:0] func;
    logic        new_func;
    logic [4:0]  cur_state;
    logic [15:0] bus;
    logic [15:0] data;
    logic [19:0] ous;
    logic [24:0] mem_out;
    logic [2:0]  reg_dis;
    logic [15:0] reg_val;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_DECODE = 5'b00010;
    localparam logic [4:0] S_EXEC1  = 5'b00100;
    localparam logic [4:0] S_EXEC2  = 5'b01000;
    localparam logic [4:0] S_DONE   = 5'b10000;

    localparam logic [2:0] LOAD = 3'b000, STORE = 3'b001, LDI = 3'b010, ADD = 3'b011;
    localparam logic [2:0] SUB = 3'b100, MOV = 3'b101, DISP = 3'b110, NOP = 3'b111;

    mc_processor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .func     (func),
        .new_func (new_func),
        .cur_state(cur_state),
        .bus      (bus),
        .data     (data),
        .ous      (ous),
        .mem_out  (mem_out),
        .reg_dis  (reg_dis),
        .reg_val  (reg_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Runs one full instruction request and returns at a falling edge in IDLE.
    task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [15:0] imm);
        @(negedge clk);
        func     = {op, rx, ry, imm};
        new_func = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        new_func = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        func     = '0;
        new_func = 1'b0;
        reg_dis  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cur_state !== S_IDLE) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %b expected %b", cur_state, S_IDLE);
        end
        for (int i = 0; i < 8; i++) begin
            reg_dis = i[2:0];
            #1;
            n_cmp++;
            if (reg_val !== 16'h0000) begin
                n_fail++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, reg_val);
            end
        end
        n_cmp++;
        if (ous !== 20'h00000) begin
            n_fail++;
            $display("[TB] FAIL reset_ous: got %h expected 00000", ous);
        end
        n_cmp++;
        if (bus !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: got %h expected 0000", bus);
        end
        n_cmp++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h expected 0000", data);
        end
    endtask

    task automatic test_ldi;
        logic [4:0] exp_states [4];
        exp_states = '{S_DECODE, S_EXEC1, S_EXEC2, S_DONE};
        @(negedge clk);
        func     = {LDI, 3'd2, 3'd0, 16'h1234};
        new_func = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (cur_state !== exp_states[i]) begin
                n_fail++;
                $display("[TB] FAIL ldi_state%0d: got %b expected %b", i, cur_state, exp_states[i]);
            end
            if (i == 0) begin
                n_cmp++;
                if (bus !== 16'h1234) begin
                    n_fail++;
                    $display("[TB] FAIL ldi_decode_bus: got %h expected 1234", bus);
                end
            end
        end
        new_func = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cur_state !== S_IDLE) begin
            n_fail++;
            $display("[TB] FAIL ldi_return_idle: got %b expected %b", cur_state, S_IDLE);
        end
        reg_dis = 3'd2;
        #1;
        n_cmp++;
        if (reg_val !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL ldi_r2: got %h expected 1234", reg_val);
        end
    endtask

    task automatic test_store_load;
        issue(STORE, 3'd2, 3'd0, 16'h0005);
        n_cmp++;
        if (mem_out !== 25'h0001234) begin
            n_fail++;
            $display("[TB] FAIL store_mem_out: got %h expected 0001234", mem_out);
        end
        issue(LOAD, 3'd3, 3'd0, 16'h0005);
        n_cmp++;
        if (data !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL load_data: got %h expected 1234", data);
        end
        reg_dis = 3'd3;
        #1;
        n_cmp++;
        if (reg_val !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL load_r3: got %h expected 1234", reg_val);
        end
        // Upper immediate bits are ignored: FFE5 addresses word 5.
        issue(LOAD, 3'd6, 3'd0, 16'hFFE5);
        reg_dis = 3'd6;
        #1;
        n_cmp++;
        if (reg_val !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL load_addr_wrap_r6: got %h expected 1234", reg_val);
        end
    endtask

    task automatic test_arith;
        issue(LDI, 3'd1, 3'd0, 16'hFFFF);
        issue(LDI, 3'd4, 3'd0, 16'h0001);
        issue(ADD, 3'd1, 3'd4, 16'h0000);
        reg_dis = 3'd1;
        #1;
        n_cmp++;
        if (reg_val !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL add_carry_drop_r1: got %h expected 0000", reg_val);
        end
        issue(SUB, 3'd4, 3'd1, 16'h0000);
        reg_dis = 3'd4;
        #1;
        n_cmp++;
        if (reg_val !== 16'h0001) begin
            n_fail++;
            $display("[TB] FAIL sub_r4: got %h expected 0001", reg_val);
        end
        issue(SUB, 3'd1, 3'd4, 16'h0000);
        reg_dis = 3'd1;
        #1;
        n_cmp++;
        if (reg_val !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL sub_wrap_r1: got %h expected ffff", reg_val);
        end
        issue(ADD, 3'd4, 3'd4, 16'h0000);
        reg_dis = 3'd4;
        #1;
        n_cmp++;
        if (reg_val !== 16'h0002) begin
            n_fail++;
            $display("[TB] FAIL add_self_r4: got %h expected 0002", reg_val);
        end
        issue(MOV, 3'd7, 3'd2, 16'h0000);
        reg_dis = 3'd7;
        #1;
        n_cmp++;
        if (reg_val !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL mov_r7: got %h expected 1234", reg_val);
        end
    endtask

    task automatic test_disp_hold;
        @(negedge clk);
        func     = {DISP, 3'd2, 3'd0, 16'h0000};
        new_func = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ous !== 20'h61234) begin
            n_fail++;
            $display("[TB] FAIL disp_ous: got %h expected 61234", ous);
        end
        func = {LDI, 3'd0, 3'd0, 16'hBEEF};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (cur_state !== S_DONE) begin
                n_fail++;
                $display("[TB] FAIL hold_done%0d: got %b expected %b", i, cur_state, S_DONE);
            end
        end
        new_func = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cur_state !== S_IDLE) begin
            n_fail++;
            $display("[TB] FAIL hold_release_idle: got %b expected %b", cur_state, S_IDLE);
        end
        reg_dis = 3'd0;
        #1;
        n_cmp++;
        if (reg_val !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL hold_ignored_func_r0: got %h expected 0000", reg_val);
        end
    endtask

    task automatic test_nop;
        @(negedge clk);
        func     = {NOP, 3'd2, 3'd2, 16'h00AA};
        new_func = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL nop_exec1_bus: got %h expected 0000", bus);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        new_func = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reg_dis = 3'd2;
        #1;
        n_cmp++;
        if (reg_val !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL nop_r2_unchanged: got %h expected 1234", reg_val);
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        func     = {LDI, 3'd5, 3'd0, 16'hABCD};
        new_func = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cur_state !== S_EXEC1) begin
            n_fail++;
            $display("[TB] FAIL abort_pre_state: got %b expected %b", cur_state, S_EXEC1);
        end
        new_func = 1'b0;
        rst_n    = 1'b0;
        reg_dis  = 3'd5;
        #1;
        n_cmp++;
        if (cur_state !== S_IDLE) begin
            n_fail++;
            $display("[TB] FAIL abort_state: got %b expected %b", cur_state, S_IDLE);
        end
        n_cmp++;
        if (reg_val !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL abort_r5: got %h expected 0000", reg_val);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (reg_val !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL abort_r5_after: got %h expected 0000", reg_val);
        end
        issue(LOAD, 3'd3, 3'd0, 16'h0005);
        reg_dis = 3'd3;
        #1;
        n_cmp++;
        if (reg_val !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL abort_mem_kept_r3: got %h expected 1234", reg_val);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_store_load();
        test_arith();
        test_disp_hold();
        test_nop();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
